// File: rtl/io_ccff_load_ctrl_if.sv
// Host-side word write handshake for the IO tile configuration-chain loader.
interface io_ccff_load_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/io_ccff_load_ctrl.sv
// Serialises host words LSB-first onto an IO-column ccff chain, sequencing isolation and config_enable.
// Define IO_CCFF_VERIFY_EN to add a recirculating CRC-8 readback pass after the load.
//
// state    | meaning
// S_IDLE   | waiting for start; IO_ISOL_N reflects last completed load
// S_ISOL   | pads isolated, settle timer running, first word may be prefetched
// S_SHIFT  | config_enable high, one bit per cycle while the buffer holds data
// S_VERIFY | chain recirculated once through ccff_tail, CRC compared
// S_SETTLE | config_enable low, timer running before isolation release
module io_ccff_load_ctrl #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8,
    parameter int ISOL_CYC  = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    io_ccff_load_ctrl_if.slave  host,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    output logic                config_enable,
    output logic                IO_ISOL_N,
    output logic                busy,
    output logic                done,
    output logic                crc_err
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BCW    = $clog2(CHAIN_LEN + 1);
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int KW     = $clog2(WORD_W + 1);
    localparam int TW     = (ISOL_CYC > 1) ? $clog2(ISOL_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISOL,
        S_SHIFT,
        S_SETTLE
`ifdef IO_CCFF_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]    words_q, words_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [KW-1:0]     buf_cnt_q, buf_cnt_d;
    logic              head_q, head_d;
    logic              shift_q, shift_d;
    logic              cfg_en_q, cfg_en_d;
    logic              isol_n_q, isol_n_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              accept;

`ifdef IO_CCFF_VERIFY_EN
    logic [7:0]     crc_a_q, crc_a_d;
    logic [7:0]     crc_b_q, crc_b_d;
    logic [BCW-1:0] vcnt_q, vcnt_d;
    logic           crc_err_q, crc_err_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        words_d   = words_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        head_d    = head_q;
        shift_d   = 1'b0;
        cfg_en_d  = cfg_en_q;
        isol_n_d  = isol_n_q;
        done_d    = 1'b0;
        accept    = host.wr_valid && ready_q;
`ifdef IO_CCFF_VERIFY_EN
        crc_a_d   = crc_a_q;
        crc_b_d   = crc_b_q;
        vcnt_d    = vcnt_q;
        crc_err_d = crc_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISOL;
                    isol_n_d  = 1'b0;
                    tmr_d     = TW'(ISOL_CYC - 1);
                    bit_cnt_d = '0;
                    words_d   = '0;
`ifdef IO_CCFF_VERIFY_EN
                    crc_err_d = 1'b0;
                    crc_a_d   = '0;
                    crc_b_d   = '0;
`endif
                end
            end
            S_ISOL: begin
                if (accept) begin
                    buf_d     = host.wr_data;
                    buf_cnt_d = KW'(WORD_W);
                    words_d   = words_q + 1'b1;
                end
                if (tmr_q == '0) begin
                    state_d  = S_SHIFT;
                    cfg_en_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHIFT: begin
                // Leave only once the last bit's shift_en cycle has been seen by the chain.
                if (bit_cnt_q == BCW'(CHAIN_LEN)) begin
                    buf_d     = '0;
                    buf_cnt_d = '0;
`ifdef IO_CCFF_VERIFY_EN
                    state_d   = S_VERIFY;
                    vcnt_d    = BCW'(CHAIN_LEN - 1);
`else
                    state_d   = S_SETTLE;
                    cfg_en_d  = 1'b0;
                    tmr_d     = TW'(ISOL_CYC - 1);
`endif
                end else if (buf_cnt_q != '0) begin
                    head_d    = buf_q[0];
                    shift_d   = 1'b1;
                    buf_d     = buf_q >> 1;
                    buf_cnt_d = buf_cnt_q - 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef IO_CCFF_VERIFY_EN
                    crc_a_d   = crc8_step(crc_a_q, buf_q[0]);
`endif
                end else if (accept) begin
                    head_d    = host.wr_data[0];
                    shift_d   = 1'b1;
                    buf_d     = host.wr_data >> 1;
                    buf_cnt_d = KW'(WORD_W - 1);
                    words_d   = words_q + 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef IO_CCFF_VERIFY_EN
                    crc_a_d   = crc8_step(crc_a_q, host.wr_data[0]);
`endif
                end
            end
`ifdef IO_CCFF_VERIFY_EN
            S_VERIFY: begin
                crc_b_d = crc8_step(crc_b_q, ccff_tail);
                if (vcnt_q == '0) begin
                    state_d   = S_SETTLE;
                    cfg_en_d  = 1'b0;
                    tmr_d     = TW'(ISOL_CYC - 1);
                    crc_err_d = (crc_a_q != crc8_step(crc_b_q, ccff_tail));
                end else begin
                    vcnt_d = vcnt_q - 1'b1;
                end
            end
`endif
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d  = S_IDLE;
                    isol_n_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (buf_cnt_d == '0) && (state_d == S_ISOL || state_d == S_SHIFT)
                  && (words_d < WCW'(NWORDS));
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            words_q   <= '0;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            head_q    <= 1'b0;
            shift_q   <= 1'b0;
            cfg_en_q  <= 1'b0;
            isol_n_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef IO_CCFF_VERIFY_EN
            crc_a_q   <= '0;
            crc_b_q   <= '0;
            vcnt_q    <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            head_q    <= head_d;
            shift_q   <= shift_d;
            cfg_en_q  <= cfg_en_d;
            isol_n_q  <= isol_n_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef IO_CCFF_VERIFY_EN
            crc_a_q   <= crc_a_d;
            crc_b_q   <= crc_b_d;
            vcnt_q    <= vcnt_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

    assign host.wr_ready = ready_q;
    assign config_enable = cfg_en_q;
    assign IO_ISOL_N     = isol_n_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

`ifdef IO_CCFF_VERIFY_EN
    // Recirculation must be combinational so the chain length is preserved.
    assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail : head_q;
    assign ccff_shift_en = (state_q == S_VERIFY) | shift_q;
    assign crc_err       = crc_err_q;
`else
    logic unused_tail;
    assign unused_tail   = ccff_tail;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_q;
    assign crc_err       = 1'b0;
`endif
endmodule

// File: tb/tb_io_ccff_load_ctrl.sv
// Directed + randomized bench for io_ccff_load_ctrl with a bit-stream / chain reference model.
module tb_io_ccff_load_ctrl;
    localparam int CL = 12;
    localparam int WW = 8;
    localparam int IC = 2;
    localparam int NW = (CL + WW - 1) / WW;
`ifdef IO_CCFF_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    logic start    = 1'b0;
    logic ccff_head, ccff_shift_en, ccff_tail;
    logic config_enable, IO_ISOL_N, busy, done, crc_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WW-1:0] wd [NW];
    logic [CL-1:0] chain_q  = '0;
    int            sh_cnt   = 0;
    int            base_sh  = 0;
    bit            fault_en = 1'b0;
    int            dur_base, dur_st, dur_x;

    io_ccff_load_ctrl_if #(.WORD_W(WW)) host ();

    io_ccff_load_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW), .ISOL_CYC(IC)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .host          (host),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .config_enable (config_enable),
        .IO_ISOL_N     (IO_ISOL_N),
        .busy          (busy),
        .done          (done),
        .crc_err       (crc_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: newest bit at index 0, tail is the oldest bit.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain_q <= {chain_q[CL-2:0], ccff_head};
            sh_cnt  <= sh_cnt + 1;
        end
    end
    assign ccff_tail = chain_q[CL-1] ^ (fault_en && (sh_cnt - base_sh == CL + 4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_shen"},  ccff_shift_en, 0);
        chk({tag, "_head"},  ccff_head, 0);
        chk({tag, "_cfgen"}, config_enable, 0);
        chk({tag, "_isoln"}, IO_ISOL_N, 0);
        chk({tag, "_ready"}, host.wr_ready, 0);
        chk({tag, "_crc"},   crc_err, 0);
    endtask

    task automatic run_load(input bit rnd, input bit hold, input int starve, input bit poke,
                            input int rst_at, input bit chk_chain, input bit crc_exp,
                            output int dur);
        int sent, n_sh, n_done, t_fall, t_rise, t_done, extra, junk, starve_left, win_sh;
        bit arm, fin, prev_cfg, prev_isol, in_win;
        logic v;
        logic [CL-1:0] got, exp_s, exp_c;
        sent = 0; n_sh = 0; n_done = 0; extra = 0; junk = 0; starve_left = 0; win_sh = 0;
        t_fall = -1; t_rise = -1; t_done = -1; dur = -1;
        arm = 1'b0; fin = 1'b0; in_win = 1'b0; got = '0;
        for (int i = 0; i < CL; i++) exp_s[i] = wd[i / WW][i % WW];
        for (int i = 0; i < CL; i++) exp_c[CL-1-i] = exp_s[i];
        @(negedge prog_clk);
        start = 1'b1;
        base_sh = sh_cnt;
        prev_cfg = config_enable;
        prev_isol = IO_ISOL_N;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge prog_clk);
            start = 1'b0;
            if (rst_at > 0 && n_sh == rst_at) begin
                pReset = 1'b0;
                host.wr_valid = 1'b0;
                @(negedge prog_clk);
                chk_rst("rst_mid");
                pReset = 1'b1;
                @(negedge prog_clk);
                chk("rst_mid_nodone", done, 0);
                chk("rst_mid_idle", busy, 0);
                return;
            end
            if (in_win) win_sh += int'(ccff_shift_en);
            if (ccff_shift_en) begin
                if (n_sh < CL) got[n_sh] = ccff_head;
                n_sh++;
            end
            if (done) begin n_done++; if (t_done < 0) t_done = c; end
            if (prev_cfg && !config_enable && t_fall < 0) t_fall = c;
            if (!prev_isol && IO_ISOL_N && t_rise < 0) t_rise = c;
            prev_cfg = config_enable;
            prev_isol = IO_ISOL_N;
            if (sent >= NW && host.wr_ready) extra++;
            if (done) begin fin = 1'b1; dur = c; end
            if (arm && host.wr_ready) begin starve_left = starve; arm = 1'b0; end
            in_win = 1'b0;
            if (sent < NW) begin
                host.wr_data = wd[sent];
                if (starve_left > 0) begin v = 1'b0; starve_left--; in_win = 1'b1; end
                else v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                host.wr_data = 8'hFF;
                v = hold;
            end
            host.wr_valid = v;
            if (v && host.wr_ready) begin
                if (sent < NW) begin
                    sent++;
                    if (sent == 1 && starve > 0) arm = 1'b1;
                end else junk++;
            end
            if (poke && busy && $urandom_range(0, 2) == 0) start = 1'b1;
        end
        host.wr_valid = 1'b0;
        start = 1'b0;
        chk("done_seen", fin, 1);
        chk("shift_count", n_sh, CL * (1 + VER));
        chk("stream", got, exp_s);
        chk("done_count", n_done, 1);
        chk("isol_after_cfg", t_rise - t_fall, IC);
        chk("done_with_isol", t_done, t_rise);
        chk("ready_after_last", extra, 0);
        chk("extra_words", junk, 0);
        chk("words_sent", sent, NW);
        if (starve > 0) chk("starve_no_shift", win_sh, 0);
        if (chk_chain) chk("chain", chain_q, exp_c);
        chk("crc_err", crc_err, crc_exp);
        @(negedge prog_clk);
        chk("no_restart", busy, 0);
        chk("done_single", done, 0);
        chk("isol_released", IO_ISOL_N, 1);
    endtask

    initial begin
        host.wr_valid = 1'b0;
        host.wr_data  = '0;
        pReset = 1'b0;
        start  = 1'b1;
        repeat (2) @(negedge prog_clk);
        chk_rst("reset");
        pReset = 1'b1;
        start  = 1'b0;
        @(negedge prog_clk);
        chk("start_in_reset_ignored", busy, 0);

        host.wr_valid = 1'b1;
        host.wr_data  = 8'hFF;
        repeat (3) begin
            @(negedge prog_clk);
            chk("idle_ready", host.wr_ready, 0);
            chk("idle_busy", busy, 0);
        end
        host.wr_valid = 1'b0;

        wd[0] = 8'hA5; wd[1] = 8'h3C;
        run_load(1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, dur_base);

        run_load(1'b0, 1'b1, 5, 1'b0, 0, 1'b1, 1'b0, dur_st);
        chk("starve_delay", dur_st - dur_base, 5);

        for (int i = 0; i < NW; i++) wd[i] = WW'($urandom_range(0, 255));
        run_load(1'b0, 1'b1, 0, 1'b0, 5, 1'b0, 1'b0, dur_x);
        for (int i = 0; i < NW; i++) wd[i] = WW'($urandom_range(0, 255));
        run_load(1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, dur_x);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW; i++) wd[i] = WW'($urandom_range(0, 255));
            run_load(1'b1, 1'($urandom_range(0, 1)), 0, 1'b1, 0, 1'b1, 1'b0, dur_x);
        end

`ifdef IO_CCFF_VERIFY_EN
        wd[0] = 8'hA5; wd[1] = 8'h3C;
        fault_en = 1'b1;
        run_load(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, dur_x);
        fault_en = 1'b0;
        run_load(1'b0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, dur_x);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
